// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int INST_W = 32;
  localparam logic [31:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    WAIT = 2'd2,
    SHOW = 2'd3
  } state_e;

endpackage

// File: rtl/fetch_sequencer_edge_detect.sv
// Rising-edge pulse for the debounced step button.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch controller: owns the PC, waits out ROM latency,
// holds one instruction stable and applies jump/branch redirects.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          ROM_AW  = 4,
  parameter int          ROM_LAT = 1,
  parameter logic [31:0] RST_PC  = 32'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              tick,
  input  logic              step,
  input  logic              jump,
  input  logic              pcsrc,
  input  logic [31:0]       jump_target,
  input  logic [31:0]       branch_target,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [INST_W-1:0] inst,
  output logic              inst_valid,
  output logic [31:0]       pc,
  output logic              busy
);

  localparam int LW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  state_e            state_q;
  logic [LW-1:0]     lat_cnt_q;
  logic [31:0]       pc_q;
  logic [31:0]       pc_d;
  logic [31:0]       npc_raw;
  logic [INST_W-1:0] inst_q;
  logic              valid_q;
  logic              step_rise;
  logic              adv;

  edge_detect u_step (
    .clk    (clk),
    .rst    (rst),
    .d_i    (step),
    .rise_o (step_rise)
  );

  assign adv = (run & tick) | step_rise;

  // jump outranks branch; targets are forced word aligned
  always_comb begin
    npc_raw = pc_q + PC_INC;
    if (jump)       npc_raw = jump_target;
    else if (pcsrc) npc_raw = branch_target;
    pc_d = {npc_raw[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      pc_q      <= RST_PC;
      inst_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (adv) state_q <= ADDR;
        end
        ADDR: begin
          lat_cnt_q <= LW'(ROM_LAT - 1);
          state_q   <= WAIT;
        end
        WAIT: begin
          if (lat_cnt_q == '0) begin
            inst_q  <= rom_data;
            valid_q <= 1'b1;
            state_q <= SHOW;
          end else begin
            lat_cnt_q <= lat_cnt_q - LW'(1);
          end
        end
        SHOW: begin
          if (adv) begin
            pc_q    <= pc_d;
            valid_q <= 1'b0;
            state_q <= ADDR;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rom_addr   = pc_q[ROM_AW+1:2];
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign busy       = (state_q == ADDR) | (state_q == WAIT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomised and directed bench for fetch_sequencer with a transaction-level model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        tick = 1'b0;
  logic        step = 1'b0;
  logic        jump = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] jump_target = '0;
  logic [31:0] branch_target = '0;
  logic [3:0]  rom_addr;
  logic [31:0] rom_data = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic        m_valid;
  int          m_pend;
  logic        m_sprev;

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ROM_AW  (4),
    .ROM_LAT (1),
    .RST_PC  (32'd0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .run           (run),
    .tick          (tick),
    .step          (step),
    .jump          (jump),
    .pcsrc         (pcsrc),
    .jump_target   (jump_target),
    .branch_target (branch_target),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .inst          (inst),
    .inst_valid    (inst_valid),
    .pc            (pc),
    .busy          (busy)
  );

  // One-cycle synchronous ROM, word k = 0x1000_0000 + k
  always @(posedge clk) rom_data <= 32'h1000_0000 + {28'd0, rom_addr};

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + ((a >> 2) & 32'd15);
  endfunction

  task automatic model_reset();
    m_pc = 32'd0; m_inst = 32'd0; m_valid = 1'b0;
    m_pend = 0; m_sprev = 1'b0;
  endtask

  // Advance one clock; the model sees the inputs that the edge sees.
  task automatic cycle();
    logic        adv;
    logic [31:0] n;
    adv = (run & tick) | (step & ~m_sprev);
    m_sprev = step;
    if (m_pend > 0) begin
      m_pend = m_pend - 1;
      if (m_pend == 0) begin
        m_valid = 1'b1;
        m_inst  = rom_word(m_pc);
      end
    end else if (adv) begin
      if (m_valid) begin
        n = jump ? jump_target : pcsrc ? branch_target : m_pc + 32'd4;
        m_pc = n & ~32'd3;
      end
      m_valid = 1'b0;
      m_pend  = 2;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    run = 0; tick = 0; step = 0; jump = 0; pcsrc = 0;
    jump_target = '0; branch_target = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pc, inst, inst_valid, busy, rom_addr} !== {32'd0, 32'd0, 1'b0, 1'b0, 4'd0}) begin
      errors++;
      $display("FAIL reset: pc=%h inst=%h v=%b busy=%b addr=%h want all zero",
               pc, inst, inst_valid, busy, rom_addr);
    end
  endtask

  task automatic test_run_tick();
    int first_valid;
    first_valid = -1;
    do_reset();
    run = 1;
    for (int c = 0; c < 8; c++) begin
      tick = (c % 4 == 0);
      cycle();
      if (inst_valid && first_valid < 0) first_valid = c;
      checks++;
      if ({pc, inst, inst_valid, busy, rom_addr} !==
          {m_pc, m_inst, m_valid, m_pend > 0, m_pc[5:2]}) begin
        errors++;
        $display("FAIL run_tick c%0d: pc=%h inst=%h v=%b b=%b want pc=%h inst=%h v=%b",
                 c, pc, inst, inst_valid, busy, m_pc, m_inst, m_valid);
      end
    end
    tick = 0;
    checks++;
    if (first_valid !== 2) begin
      errors++;
      $display("FAIL run_tick_latency: got %0d want 2", first_valid);
    end
    checks++;
    if ({pc, inst} !== {32'd4, 32'h1000_0001}) begin
      errors++;
      $display("FAIL run_tick_end: pc=%h inst=%h want 4 10000001", pc, inst);
    end
  endtask

  task automatic test_step();
    do_reset();
    run = 1; tick = 1;
    cycle();
    tick = 0; run = 0;
    repeat (3) cycle();
    step = 1;
    for (int c = 0; c < 10; c++) begin
      cycle();
      checks++;
      if ({pc, inst, inst_valid, busy} !== {m_pc, m_inst, m_valid, m_pend > 0}) begin
        errors++;
        $display("FAIL step c%0d: pc=%h inst=%h v=%b want pc=%h inst=%h v=%b",
                 c, pc, inst, inst_valid, m_pc, m_inst, m_valid);
      end
    end
    step = 0;
    repeat (3) cycle();
    checks++;
    if ({pc, inst, inst_valid} !== {32'd4, 32'h1000_0001, 1'b1}) begin
      errors++;
      $display("FAIL step_once: pc=%h inst=%h v=%b want 4 10000001 1",
               pc, inst, inst_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    run = 1;
    for (int a = 0; a < 17; a++) begin
      tick = 1;
      cycle();
      tick = 0;
      repeat (3) cycle();
      if (a == 15) begin
        checks++;
        if ({pc, inst, rom_addr} !== {32'h3C, 32'h1000_000F, 4'hF}) begin
          errors++;
          $display("FAIL wrap_pre: pc=%h inst=%h addr=%h want 3c 1000000f f",
                   pc, inst, rom_addr);
        end
      end
    end
    checks++;
    if ({pc, inst, rom_addr, inst_valid} !== {32'h40, 32'h1000_0000, 4'h0, 1'b1}) begin
      errors++;
      $display("FAIL wrap: pc=%h inst=%h addr=%h v=%b want 40 10000000 0 1",
               pc, inst, rom_addr, inst_valid);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    run = 1;
    for (int a = 0; a < 3; a++) begin
      tick = 1; cycle(); tick = 0;
      repeat (3) cycle();
    end
    jump = 1; jump_target = 32'h20; pcsrc = 1; branch_target = 32'h30;
    tick = 1; cycle();
    tick = 0; jump = 0; pcsrc = 0;
    repeat (3) cycle();
    checks++;
    if ({pc, inst} !== {32'h20, 32'h1000_0008}) begin
      errors++;
      $display("FAIL jump_prio: pc=%h inst=%h want 20 10000008", pc, inst);
    end
    pcsrc = 1; branch_target = 32'h31;
    tick = 1; cycle();
    tick = 0; pcsrc = 0;
    repeat (3) cycle();
    checks++;
    if ({pc, inst} !== {32'h30, 32'h1000_000C}) begin
      errors++;
      $display("FAIL branch_align: pc=%h inst=%h want 30 1000000c", pc, inst);
    end
  endtask

  task automatic test_drop();
    do_reset();
    run = 1;
    tick = 1; cycle(); tick = 0;
    repeat (3) cycle();
    tick = 1;
    repeat (3) cycle();
    tick = 0;
    repeat (2) cycle();
    checks++;
    if ({pc, inst, inst_valid} !== {32'h4, 32'h1000_0001, 1'b1}) begin
      errors++;
      $display("FAIL drop_busy: pc=%h inst=%h v=%b want 4 10000001 1",
               pc, inst, inst_valid);
    end
    tick = 1; step = 1; cycle();
    tick = 0;
    repeat (4) cycle();
    step = 0;
    checks++;
    if ({pc, inst} !== {32'h8, 32'h1000_0002}) begin
      errors++;
      $display("FAIL tick_step_same: pc=%h inst=%h want 8 10000002", pc, inst);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      run   = ($urandom_range(0, 3) != 0);
      tick  = ($urandom_range(0, 2) == 0);
      step  = ($urandom_range(0, 3) == 0);
      jump  = ($urandom_range(0, 7) == 0);
      pcsrc = ($urandom_range(0, 5) == 0);
      jump_target   = $urandom;
      branch_target = $urandom;
      cycle();
      checks++;
      if ({pc, inst, inst_valid, busy, rom_addr} !==
          {m_pc, m_inst, m_valid, m_pend > 0, m_pc[5:2]}) begin
        errors++;
        $display("FAIL random c%0d: pc=%h inst=%h v=%b b=%b want pc=%h inst=%h v=%b b=%b",
                 c, pc, inst, inst_valid, busy, m_pc, m_inst, m_valid, m_pend > 0);
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    run = 1;
    for (int a = 0; a < 3; a++) begin
      tick = 1; cycle(); tick = 0;
      repeat (3) cycle();
    end
    tick = 1; cycle(); tick = 0;
    cycle();
    checks++;
    if (busy !== 1'b1 || pc !== 32'hC) begin
      errors++;
      $display("FAIL mid_setup: busy=%b pc=%h want 1 c", busy, pc);
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({pc, inst, inst_valid, busy} !== {32'd0, 32'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: pc=%h inst=%h v=%b b=%b want 0 0 0 0",
               pc, inst, inst_valid, busy);
    end
    clear_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    repeat (2) cycle();
    checks++;
    if ({inst_valid, busy, pc} !== {1'b0, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL post_reset_idle: v=%b b=%b pc=%h want 0 0 0", inst_valid, busy, pc);
    end
    run = 1; tick = 1; cycle(); tick = 0;
    repeat (3) cycle();
    checks++;
    if ({pc, inst, inst_valid} !== {32'd0, 32'h1000_0000, 1'b1}) begin
      errors++;
      $display("FAIL idle_fetch: pc=%h inst=%h v=%b want 0 10000000 1",
               pc, inst, inst_valid);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_run_tick();
    test_step();
    test_wrap();
    test_redirect();
    test_drop();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
